// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and channel select type
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEF  = 16;
    localparam int unsigned SLOT_BITS_DEF = 32;
    localparam int unsigned BCLK_DIV_DEF  = 4;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } lr_sel;

endpackage

// File: rtl/bclk_gen.sv
// rtl/bclk_gen.sv - bit clock divider with edge strobes aligned to the toggle clk
module bclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic bclk,
    output logic bclk_fall,
    output logic bclk_rise
);

    localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    // Strobes fire on the clk whose edge toggles bclk, so dependents update with it.
    assign wrap      = (div_cnt == DIV_LAST);
    assign bclk_fall = wrap & bclk;
    assign bclk_rise = wrap & ~bclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) begin
                bclk <= ~bclk;
            end
        end
    end

endmodule

// File: rtl/codec_adc_tx.sv
// rtl/codec_adc_tx.sv - I2S stereo serial transmitter with one-entry sample buffer
module codec_adc_tx
    import audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV  = BCLK_DIV_DEF,
    parameter int unsigned SAMPLE_W  = SAMPLE_W_DEF,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                adclrc,
    output logic                adcdat,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned CW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] SLOT_LEN  = CW'(SLOT_BITS);
    localparam logic [CW-1:0] DATA_LAST = CW'(SAMPLE_W);

    logic                bclk_fall;
    logic                bclk_rise;
    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       bit_nxt;
    logic [CW-1:0]       slot_pos;
    lr_sel               lr_nxt;
    logic [SAMPLE_W-1:0] buf_l, buf_r;
    logic [SAMPLE_W-1:0] left_sr, right_sr;
    logic [SAMPLE_W-1:0] chan, chan_shift;
    logic                buf_full;
    logic                xfer;
    logic                frame_load;
    logic                dat_nxt;

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .bclk_fall (bclk_fall),
        .bclk_rise (bclk_rise)
    );

    assign sample_ready = ~buf_full;
    assign xfer         = sample_valid & ~buf_full;

    // Everything is computed for the bit position being entered at this fall.
    always_comb begin
        bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        lr_nxt     = (bit_nxt >= SLOT_LEN) ? RIGHT : LEFT;
        slot_pos   = (lr_nxt == RIGHT) ? bit_nxt - SLOT_LEN : bit_nxt;
        chan       = (lr_nxt == RIGHT) ? right_sr : left_sr;
        chan_shift = chan >> (DATA_LAST - slot_pos);
        dat_nxt    = (slot_pos != '0) && (slot_pos <= DATA_LAST) && chan_shift[0];
        frame_load = bclk_fall && (bit_nxt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= BIT_LAST;
            adclrc      <= 1'b1;
            adcdat      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            left_sr     <= '0;
            right_sr    <= '0;
        end else begin
            frame_start <= frame_load;
            underrun    <= frame_load & ~buf_full;
            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                adclrc  <= lr_nxt;
                adcdat  <= dat_nxt;
            end
            // An empty buffer leaves the previous pair in place for retransmission.
            if (frame_load && buf_full) begin
                left_sr  <= buf_l;
                right_sr <= buf_r;
            end
            if (xfer) begin
                buf_l    <= left_in;
                buf_r    <= right_in;
                buf_full <= 1'b1;
            end else if (frame_load) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: doc/codec_adc_tx.md
# codec_adc_tx

Codec-side serial audio transmitter, the far end of the audio ADC receiver. Takes parallel stereo samples through a one-entry valid/ready buffer and generates the bit clock, the left/right frame clock and the serial data in I2S format. It drives the receiver pins (`bclk`, `adclrc`, `adcdat`) in loopback benches, and gives the FPGA a self-generated audio source when no codec is fitted.

## Interface
- `BCLK_DIV`, default 4: clk cycles per bclk half-period; legal range ≥1.
- `SAMPLE_W`, default 16: bits per channel sample.
- `SLOT_BITS`, default 32: bclk periods per channel slot; must be ≥ SAMPLE_W+1.
- `clk` input, 1 bit: single system clock; all logic runs on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `left_in` input, SAMPLE_W bits: left sample, two's complement.
- `right_in` input, SAMPLE_W bits: right sample, two's complement.
- `sample_valid` input, 1 bit: left_in/right_in hold a stereo pair.
- `sample_ready` output, 1 bit: holding buffer is empty.
- `bclk` output, 1 bit: serial bit clock, registered.
- `adclrc` output, 1 bit: frame clock; 0 = left slot, 1 = right slot.
- `adcdat` output, 1 bit: serial data, MSB first.
- `frame_start` output, 1 bit: one-clk pulse when a new frame is loaded.
- `underrun` output, 1 bit: one-clk pulse when a frame loads with the holding buffer empty.

## Operation
- Divider: `div_cnt` counts 0..BCLK_DIV-1. When it wraps, bclk toggles.
- Bclk falling edge (the clk where bclk goes 1→0): `bit_cnt` advances modulo 2*SLOT_BITS, and adclrc/adcdat update in the same clk. The receiver samples on the bclk rising edge.
- Slot position `p = bit_cnt mod SLOT_BITS`.
  - adclrc = (bit_cnt ≥ SLOT_BITS).
  - adcdat at p=0: 0 (I2S one-bit delay).
  - adcdat at p=1..SAMPLE_W: sample bit SAMPLE_W-p, MSB first.
  - adcdat at p>SAMPLE_W: 0.
- Holding buffer: a transfer happens when sample_valid && sample_ready. The pair is captured and sample_ready drops on the next clk.
- Frame load (bit_cnt wraps to 0):
  - If the buffer is full, copy it into the left/right shift registers and mark the buffer empty.
  - If the buffer is empty, retransmit the previous pair and pulse underrun.
  - frame_start pulses in both cases.
- Frame load and a transfer in the same clk: the load takes the old buffer contents and the new pair is captured. Net effect: buffer full, sample_ready=0.
- left_in/right_in are ignored while sample_valid=0 or sample_ready=0.

## Timing
- Reset values:
  - bclk=0, adclrc=1, adcdat=0, frame_start=0, underrun=0, sample_ready=1.
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - Shift registers and buffer cleared to 0.
- After reset: first bclk rise at clk BCLK_DIV, first fall at clk 2*BCLK_DIV.
  - That first fall enters p=0 of the left slot: frame load, adclrc→0.
  - No sample loaded before this point means underrun fires and zeros are sent.
- Frame period = 2*SLOT_BITS*2*BCLK_DIV clk (512 clk at defaults).
- Latency from accepted pair to left MSB on adcdat: up to one frame wait, plus one bclk period after frame_start.
- Reset asserted mid-frame: all state returns to reset values immediately and the partial frame is discarded.

## Structure
- Shared package `audio_pkg`: SAMPLE_W default, I2S slot constants, and an `lr_sel` enum (LEFT=0, RIGHT=1). The ADC receiver and DAC blocks use the same package.
- One sub-module `bclk_gen`: holds the divider and bclk register, and outputs a one-clk `bclk_fall` strobe and `bclk_rise` strobe.
- `codec_adc_tx` holds the bit counter, holding buffer, shift registers and pulse logic.

## Test plan
- Reset, then present pair L=16'hA5F0, R=16'h0F0F before the first fall:
  - Left slot bits 1..16 read A5F0 MSB-first on the bclk rising edges; right slot reads 0F0F.
  - Padding bits are 0; underrun never pulses.
- No sample after reset: frame_start and underrun both pulse at clk 2*BCLK_DIV; adcdat stays 0 for the whole frame.
- Load 16'h8001/16'h7FFF once, then hold sample_valid=0: a second frame repeats 8001/7FFF and underrun pulses at its load.
- Hold sample_valid=1 continuously with an incrementing counter: exactly one pair is accepted per 512 clk, and the transmitted values step by exactly 1 per frame.
- Drive sample_valid on exactly the frame-load clk: the old pair is transmitted, the new pair is sent in the next frame, and sample_ready=0 between the two loads.
- Assert reset at bit_cnt=20 of the right slot: outputs go to their reset values at once, and the next frame_start lands at exactly 2*BCLK_DIV clk after reset is released.
- Cross-check (all of the above): run with BCLK_DIV=1 and SLOT_BITS=17; the loopback through the ADC receiver returns identical samples.
